// File: rtl/aes_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_arb_pkg
// Description : Shared types and constants for the AES128 core arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_arb_pkg;

    localparam int AES_BLOCK_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    // A single requester index still needs one bit on the response channel.
    function automatic int aes_arb_id_w(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_core_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker; search starts after last_grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_grant_i,
    output logic [NUM_REQ-1:0] grant_oh_o,
    output logic [ID_W-1:0]    grant_idx_o,
    output logic               any_req_o
);

    always_comb begin
        int   w_cand;
        logic w_found;
        grant_oh_o  = '0;
        grant_idx_o = '0;
        w_found     = 1'b0;
        w_cand      = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_cand = int'(last_grant_i) + i;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            if (!w_found && req_i[w_cand[ID_W-1:0]]) begin
                w_found                        = 1'b1;
                grant_oh_o[w_cand[ID_W-1:0]]   = 1'b1;
                grant_idx_o                    = w_cand[ID_W-1:0];
            end
        end
    end

    assign any_req_o = |req_i;

endmodule
`default_nettype wire

// File: rtl/aes_core_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : aes_core_arbiter
// Description : Round-robin sharing of one AES128 core between NUM_REQ
//               requesters. Optional BUSY watchdog: AES_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_core_arbiter
    import aes_arb_pkg::*;
#(
    parameter int  NUM_REQ        = 2,
    parameter int  TIMEOUT_CYCLES = 64,
    localparam int ID_W           = aes_arb_id_w(NUM_REQ)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ*AES_BLOCK_W-1:0] req_key_i,
    input  logic [NUM_REQ*AES_BLOCK_W-1:0] req_text_i,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic [ID_W-1:0]                rsp_id_o,
    output logic [AES_BLOCK_W-1:0]         rsp_cipher_o,
    output logic                           rsp_err_o,
    output logic [AES_BLOCK_W-1:0]         core_key_o,
    output logic [AES_BLOCK_W-1:0]         core_text_o,
    output logic                           core_start_o,
    input  logic                           core_done_i,
    input  logic [AES_BLOCK_W-1:0]         core_cipher_i,
    output logic                           busy_o
);

    localparam logic [ID_W-1:0] C_LAST_GRANT_RST = ID_W'(NUM_REQ - 1);

    arb_state_e             state_q, state_d;
    logic [ID_W-1:0]        last_grant_q, last_grant_d;
    logic [ID_W-1:0]        rsp_id_q, rsp_id_d;
    logic [AES_BLOCK_W-1:0] rsp_cipher_q, rsp_cipher_d;
    logic [AES_BLOCK_W-1:0] core_key_q, core_key_d;
    logic [AES_BLOCK_W-1:0] core_text_q, core_text_d;
    logic                   done_q, done_d;

    logic [NUM_REQ-1:0]     w_grant_oh;
    logic [ID_W-1:0]        w_grant_idx;
    logic                   w_any_req;
    logic                   w_done_edge;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req_i        (req_valid_i),
        .last_grant_i (last_grant_q),
        .grant_oh_o   (w_grant_oh),
        .grant_idx_o  (w_grant_idx),
        .any_req_o    (w_any_req)
    );

    // Edge detect so a done level left high by the previous op cannot complete this one.
    assign w_done_edge = core_done_i & ~done_q;

`ifdef AES_ARB_TIMEOUT_EN
    localparam int               CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic             rsp_err_q, rsp_err_d;
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rsp_id_d     = rsp_id_q;
        rsp_cipher_d = rsp_cipher_q;
        core_key_d   = core_key_q;
        core_text_d  = core_text_q;
        done_d       = core_done_i;
`ifdef AES_ARB_TIMEOUT_EN
        to_cnt_d     = to_cnt_q;
        rsp_err_d    = rsp_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (w_any_req) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (w_grant_oh[i]) begin
                            core_key_d  = req_key_i[i*AES_BLOCK_W +: AES_BLOCK_W];
                            core_text_d = req_text_i[i*AES_BLOCK_W +: AES_BLOCK_W];
                        end
                    end
                    rsp_id_d     = w_grant_idx;
                    last_grant_d = w_grant_idx;
                    state_d      = ST_START;
                end
            end
            ST_START: begin
`ifdef AES_ARB_TIMEOUT_EN
                to_cnt_d = '0;
`endif
                state_d  = ST_BUSY;
            end
            ST_BUSY: begin
                if (w_done_edge) begin
                    rsp_cipher_d = core_cipher_i;
`ifdef AES_ARB_TIMEOUT_EN
                    rsp_err_d    = 1'b0;
`endif
                    state_d      = ST_RESP;
                end
`ifdef AES_ARB_TIMEOUT_EN
                else if (to_cnt_q == C_CNT_LAST) begin
                    rsp_cipher_d = '0;
                    rsp_err_d    = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    to_cnt_d = to_cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            last_grant_q <= C_LAST_GRANT_RST;
            rsp_id_q     <= '0;
            rsp_cipher_q <= '0;
            core_key_q   <= '0;
            core_text_q  <= '0;
            done_q       <= 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
            to_cnt_q     <= '0;
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_id_q     <= rsp_id_d;
            rsp_cipher_q <= rsp_cipher_d;
            core_key_q   <= core_key_d;
            core_text_q  <= core_text_d;
            done_q       <= done_d;
`ifdef AES_ARB_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
            rsp_err_q    <= rsp_err_d;
`endif
        end
    end

    assign req_ready_o  = (state_q == ST_IDLE) ? w_grant_oh : '0;
    assign rsp_valid_o  = (state_q == ST_RESP);
    assign core_start_o = (state_q == ST_START);
    assign busy_o       = (state_q != ST_IDLE);
    assign rsp_id_o     = rsp_id_q;
    assign rsp_cipher_o = rsp_cipher_q;
    assign core_key_o   = core_key_q;
    assign core_text_o  = core_text_q;
`ifdef AES_ARB_TIMEOUT_EN
    assign rsp_err_o    = rsp_err_q;
`else
    assign rsp_err_o    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_core_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_core_arbiter
// Description : Directed scoreboard bench for aes_core_arbiter with a core stub.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_core_arbiter;
    import aes_arb_pkg::*;

    localparam int NUM_REQ        = 2;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int ID_W           = 1;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*128-1:0] req_key;
    logic [NUM_REQ*128-1:0] req_text;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [127:0]           rsp_cipher;
    logic                   rsp_err;
    logic [127:0]           core_key;
    logic [127:0]           core_text;
    logic                   core_start;
    logic                   core_done   = 1'b0;
    logic [127:0]           core_cipher = '0;
    logic                   busy;

    always #5 clk = ~clk;

    aes_core_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_key_i     (req_key),
        .req_text_i    (req_text),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_id_o      (rsp_id),
        .rsp_cipher_o  (rsp_cipher),
        .rsp_err_o     (rsp_err),
        .core_key_o    (core_key),
        .core_text_o   (core_text),
        .core_start_o  (core_start),
        .core_done_i   (core_done),
        .core_cipher_i (core_cipher),
        .busy_o        (busy)
    );

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [127:0]    cipher;
        logic            err;
    } rsp_t;

    rsp_t sb_q[$];
    int   grant_log[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Stand-in for the AES128 core: exact FIPS-197 answer, otherwise a keyed mix.
    function automatic logic [127:0] core_model(input logic [127:0] k, input logic [127:0] t);
        if (k == FIPS_KEY && t == FIPS_PT) return FIPS_CT;
        return k ^ {t[63:0], t[127:64]} ^ 128'hA5A5_5A5A_0F0F_F0F0_3C3C_C3C3_9696_6969;
    endfunction

    // Mode 0: done pulse after stub_lat; 1: done held high, dropped, re-raised at +12; 2: never.
    int           stub_mode = 0;
    int           stub_lat  = 5;
    int           stub_cnt  = -1;
    logic [127:0] stub_k    = '0;
    logic [127:0] stub_t    = '0;

    always @(negedge clk) begin
        if (rst) begin
            stub_cnt = -1;
        end else if (core_start) begin
            stub_cnt = 0;
            stub_k   = core_key;
            stub_t   = core_text;
        end else if (stub_cnt >= 0 && stub_cnt < 1000) begin
            stub_cnt++;
        end
        case (stub_mode)
            0: begin
                core_done = (stub_cnt == stub_lat);
                if (core_done) core_cipher = core_model(stub_k, stub_t);
            end
            1: begin
                core_done   = !(stub_cnt >= 2 && stub_cnt < 12);
                core_cipher = (stub_cnt >= 12) ? core_model(stub_k, stub_t) : '1;
            end
            default: begin
                core_done   = 1'b0;
                core_cipher = '1;
            end
        endcase
    end

    int   cyc = 0;
    int   acc_cnt = 0;
    int   acc_cyc = -100;
    int   start_cyc = -100;
    int   rsp_delay = 6;
    logic prev_start = 1'b0;
    logic prev_rsp = 1'b0;
    rsp_t e_push;
    rsp_t e_exp;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            prev_start = 1'b0;
            prev_rsp   = 1'b0;
        end else begin
            if (busy) check("ready_while_busy", 128'(req_ready), 128'(0));
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && req_valid[i]) begin
                    e_push.id     = ID_W'(i);
                    e_push.err    = (stub_mode == 2);
                    e_push.cipher = (stub_mode == 2) ? '0 :
                                    core_model(req_key[i*128 +: 128], req_text[i*128 +: 128]);
                    sb_q.push_back(e_push);
                    grant_log.push_back(i);
                    acc_cnt++;
                    acc_cyc = cyc;
                end
            end
            if (core_start) begin
                check("start_at_T+1", 128'(cyc), 128'(acc_cyc + 1));
                check("start_single_cycle", 128'(prev_start), 128'(0));
                start_cyc = cyc;
            end
            prev_start = core_start;
            if (rsp_valid && !prev_rsp) check("rsp_latency", 128'(cyc - start_cyc), 128'(rsp_delay));
            prev_rsp = rsp_valid;
            if (rsp_valid && rsp_ready) begin
                check("sb_has_entry", 128'(sb_q.size() != 0), 128'(1));
                if (sb_q.size() != 0) begin
                    e_exp = sb_q.pop_front();
                    check("rsp_id", 128'(rsp_id), 128'(e_exp.id));
                    check("rsp_cipher", rsp_cipher, e_exp.cipher);
                    check("rsp_err", 128'(rsp_err), 128'(e_exp.err));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accepts(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (acc_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, 128'(acc_cnt >= target), 128'(1));
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        check(tag, 128'(sb_q.size() == 0 && !busy), 128'(1));
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_req_ready"},  128'(req_ready),  128'(0));
        check({pfx, "_rsp_valid"},  128'(rsp_valid),  128'(0));
        check({pfx, "_rsp_id"},     128'(rsp_id),     128'(0));
        check({pfx, "_rsp_cipher"}, rsp_cipher,       128'(0));
        check({pfx, "_rsp_err"},    128'(rsp_err),    128'(0));
        check({pfx, "_core_key"},   core_key,         128'(0));
        check({pfx, "_core_text"},  core_text,        128'(0));
        check({pfx, "_core_start"}, 128'(core_start), 128'(0));
        check({pfx, "_busy"},       128'(busy),       128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           base;
        int           h;
        logic [ID_W-1:0] snap_id;
        logic [127:0] snap_cipher;
        int           n;

        rst       = 1'b1;
        req_valid = '0;
        req_key   = '0;
        req_text  = '0;
        rsp_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check_reset("reset");

        // FIPS-197 vector from requester 0
        req_key[127:0]  = FIPS_KEY;
        req_text[127:0] = FIPS_PT;
        req_valid       = 2'b01;
        wait_accepts(1, 20, "fips_accept");
        req_valid = '0;
        wait_drain(50, "fips_drain");
        check("core_key_hold", core_key, FIPS_KEY);
        check("core_text_hold", core_text, FIPS_PT);

        // Round robin from reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        grant_log.delete();
        req_key   = {128'h1111_2222_3333_4444_5555_6666_7777_8888, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555};
        req_text  = {128'hCAFE_F00D_1234_5678_9ABC_DEF0_0F1E_2D3C, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
        base      = acc_cnt;
        req_valid = 2'b11;
        wait_accepts(base + 4, 200, "rr_accepts");
        req_valid = '0;
        wait_drain(60, "rr_drain");
        check("rr_count", 128'(grant_log.size()), 128'(4));
        for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
            check("rr_grant", 128'(grant_log[i]), 128'(i % 2));
        end

        // Response backpressure
        rsp_ready = 1'b0;
        base      = acc_cnt;
        req_valid = 2'b01;
        wait_accepts(base + 1, 20, "bp_accept");
        req_valid = 2'b10;
        n = 0;
        while (!rsp_valid && n < 30) begin
            tick();
            n++;
        end
        check("bp_rsp_seen", 128'(rsp_valid), 128'(1));
        snap_id     = rsp_id;
        snap_cipher = rsp_cipher;
        base        = acc_cnt;
        repeat (10) begin
            tick();
            check("bp_valid_hold", 128'(rsp_valid), 128'(1));
            check("bp_id_hold", 128'(rsp_id), 128'(snap_id));
            check("bp_cipher_hold", rsp_cipher, snap_cipher);
        end
        check("bp_no_grant", 128'(acc_cnt), 128'(base));
        rsp_ready = 1'b1;
        h = cyc;
        wait_accepts(base + 1, 5, "bp_next_grant");
        req_valid = '0;
        check("bp_grant_cycle", 128'(acc_cyc), 128'(h + 1));
        check("bp_grant_id", 128'(grant_log[grant_log.size()-1]), 128'(1));
        wait_drain(50, "bp_drain");

        // Stale done level: only the re-raise 12 cycles after start counts
        stub_mode = 1;
        rsp_delay = 13;
        for (int k = 0; k < 2; k++) begin
            req_key[127:0]  = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100 ^ 128'(k);
            req_text[127:0] = 128'hFFEE_DDCC_BBAA_9988_7766_5544_3322_1100 + 128'(k);
            base            = acc_cnt;
            req_valid       = 2'b01;
            wait_accepts(base + 1, 20, "stale_accept");
            req_valid = '0;
            wait_drain(60, "stale_drain");
        end

        stub_mode = 2;
`ifdef AES_ARB_TIMEOUT_EN
        rsp_delay = 17;
        base      = acc_cnt;
        req_valid = 2'b01;
        wait_accepts(base + 1, 20, "to_accept");
        req_valid = '0;
        wait_drain(60, "to_drain");
`endif

        // Core never finishes; reset in BUSY then a normal op
        base      = acc_cnt;
        req_valid = 2'b01;
        wait_accepts(base + 1, 20, "midrst_accept");
        req_valid = '0;
`ifdef AES_ARB_TIMEOUT_EN
        repeat (5) tick();
`else
        repeat (40) tick();
`endif
        check("midrst_busy", 128'(busy), 128'(1));
        check("midrst_no_rsp", 128'(rsp_valid), 128'(0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset("midrst");

        stub_mode       = 0;
        rsp_delay       = 6;
        req_key[127:0]  = 128'h2B7E_1516_28AE_D2A6_ABF7_1588_09CF_4F3C;
        req_text[127:0] = 128'h3243_F6A8_885A_308D_3131_98A2_E037_0734;
        base            = acc_cnt;
        req_valid       = 2'b01;
        wait_accepts(base + 1, 20, "post_accept");
        req_valid = '0;
        wait_drain(50, "post_drain");
        check("post_core_key", core_key, 128'h2B7E_1516_28AE_D2A6_ABF7_1588_09CF_4F3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_core_arbiter.md
# aes_core_arbiter

Shares one AES128 encryption core between `NUM_REQ` requesters. Each requester presents a key and plaintext over a valid/ready channel. The block grants requesters round-robin, loads the core, pulses start and waits for the core's done indication. It then returns the ciphertext on a single response channel tagged with the requester ID. It sits between bus-side request sources (for example several AHB-Lite register front-ends or DMA clients) and the single AES128 instance.

## Interface
- `NUM_REQ`, default 2: number of requesters, range 2..8.
- `TIMEOUT_CYCLES`, default 64: watchdog limit in BUSY. Used only when `AES_ARB_TIMEOUT_EN` is defined.
- `clk_i`, in, 1: the only clock. Every register in the block updates on its rising edge.
- `rst_i`, in, 1: synchronous, active-high reset.
- `req_valid_i`, in, NUM_REQ: per-requester request valid.
- `req_ready_o`, out, NUM_REQ: per-requester accept, one-hot or zero.
- `req_key_i`, in, NUM_REQ*128: packed keys. Requester i occupies [128i+127:128i].
- `req_text_i`, in, NUM_REQ*128: packed plaintexts, same packing as `req_key_i`.
- `rsp_valid_o`, out, 1: response valid.
- `rsp_ready_i`, in, 1: response accept.
- `rsp_id_o`, out, ID_W: index of the granted requester. ID_W = max(1, clog2(NUM_REQ)).
- `rsp_cipher_o`, out, 128: ciphertext.
- `rsp_err_o`, out, 1: core timeout flag.
- `core_key_o`, out, 128: key to the AES core, registered.
- `core_text_o`, out, 128: plaintext to the AES core, registered.
- `core_start_o`, out, 1: start pulse to the core.
- `core_done_i`, in, 1: core data_ready; may be a level or a pulse.
- `core_cipher_i`, in, 128: core ciphertext output.
- `busy_o`, out, 1: high in every state except IDLE.

## Operation
States: IDLE, START, BUSY, RESP.

- **IDLE**
  - If any `req_valid_i` bit is set, the round-robin picker selects grant g.
  - The search starts at last_grant+1 and wraps modulo NUM_REQ.
  - In the same cycle, `req_ready_o[g]`=1 (combinational from state and valid); the request handshake completes.
  - On that edge, register: `core_key_o`/`core_text_o` ← slice g; id ← g; last_grant ← g. Go to START.
- **START**
  - `core_start_o`=1 for exactly this cycle.
  - Clear the timeout counter. Go to BUSY.
- **BUSY**
  - Done is detected on the rising edge of `core_done_i` (done=1 and done_q=0). done_q is a one-cycle registered copy.
  - A done level left over from the previous operation is therefore ignored.
  - On detection: capture `core_cipher_i` into `rsp_cipher_o`, set `rsp_err_o`=0, go to RESP.
- **RESP**
  - `rsp_valid_o`=1; `rsp_id_o`, `rsp_cipher_o` and `rsp_err_o` are held stable until `rsp_ready_i`=1.
  - On that handshake, go to IDLE.
- `req_ready_o` is 0 in every state except IDLE. Only one operation is in flight at a time.
- `core_key_o`/`core_text_o` hold their value from grant until the next grant.
- Round-robin example: requesters 0 and 1 both valid continuously, reset state → grants 0, 1, 0, 1, …
  - After reset, last_grant = NUM_REQ-1, so requester 0 wins first.

## Timing
- Reset values: state=IDLE, `req_ready_o`=0, `rsp_valid_o`=0, `rsp_id_o`=0, `rsp_cipher_o`=0, `rsp_err_o`=0, `core_key_o`=0, `core_text_o`=0, `core_start_o`=0, `busy_o`=0, done_q=0, last_grant=NUM_REQ-1.
- Request accepted at cycle T.
  - `core_start_o` is high at T+1.
  - Done rising edge is seen at cycle D ≥ T+2.
  - `rsp_valid_o` is high from D+1.
- The earliest next grant is the cycle after the response handshake. Minimum op period = core latency + 4 cycles.
- If a done rising edge occurs during START, it is ignored; done_q still updates.
- Reset mid-operation: everything returns to reset values on the next edge. An in-flight response is dropped; the core is not otherwise signalled.
- Requesters may deassert `req_valid_i` before a grant without penalty.

## Configuration
- `AES_ARB_TIMEOUT_EN` defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) increments every BUSY cycle.
  - If it reaches TIMEOUT_CYCLES without a done edge, go to RESP with `rsp_err_o`=1 and `rsp_cipher_o`=0.
  - A done edge seen in the same cycle as the limit wins; no error.
- `AES_ARB_TIMEOUT_EN` undefined: no counter exists, `rsp_err_o` is tied to 0, and BUSY waits indefinitely.

## Structure
- Package `aes_arb_pkg`:
  - state enum (IDLE/START/BUSY/RESP);
  - `AES_BLOCK_W`=128;
  - a helper function computing ID_W.
- Sub-module `rr_arbiter`: combinational round-robin picker. Inputs: request vector, last_grant. Outputs: one-hot grant, grant index, any-request.

## Test plan
- **FIPS-197 vector.** Requester 0 sends key 000102030405060708090a0b0c0d0e0f and plaintext 00112233445566778899aabbccddeeff through the real AES128 → response id 0, cipher 69c4e0d86a7b0430d8cdb78070b4c55a, err 0. Check `core_start_o` is high exactly one cycle, at T+1.
- **Round robin.** Requesters 0 and 1 hold valid for 4 ops → grants 0, 1, 0, 1. `req_ready_o` is never high while `busy_o`=1.
- **Response backpressure.** Hold `rsp_ready_i`=0 for 10 cycles → `rsp_valid_o`, id and cipher stay stable; no new grant until the handshake.
- **Stale done.** A core stub holds done high across operations, then drops it and re-raises it 12 cycles after start → capture occurs only on the re-raise.
- **Timeout.** With `AES_ARB_TIMEOUT_EN` and TIMEOUT_CYCLES=16, the stub never asserts done → response 17 cycles after start with err=1 and cipher 0. Without the macro, the block stays in BUSY.
- **Mid-operation reset.** Assert `rst_i` for one cycle in BUSY → all outputs return to reset values. The next request from requester 0 completes normally.
